handshake_fifo: RTL and testbench

//  Elastic buffer between the source and drain stages of the handshake path.
//  - Consumes words from an upstream handshake.dir2 interface and replays them in order on a downstream handshake.dir1 interface.
//  - Absorbs drain stalls so the source can keep issuing.
//  - Field mapping on each interface:
//    - port1[WIDTH-1] = valid, port1[WIDTH-2:0] = payload.
//    - port2[0] = ready; port2[WIDTH-1:1] are driven 0 and ignored on input.

---
 rtl/handshake_pkg.sv | 48 ++++
 rtl/handshake.sv | 10 +
 rtl/hs_fifo_mem.sv | 25 ++
 rtl/handshake_fifo.sv | 117 +++++++++++
 tb/tb_handshake_fifo.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_pkg.sv
// Field layout helpers shared by every handshake endpoint: bit positions, beat struct,
// and pack/unpack between the raw port1/port2 vectors and a decoded beat.
package handshake_pkg;

  localparam int unsigned HS_MAX_W  = 64;
  localparam int unsigned HS_IDX_W  = $clog2(HS_MAX_W);
  localparam int unsigned READY_BIT = 0;

  typedef struct packed {
    logic                  valid;
    logic [HS_MAX_W-2:0]   payload;
  } hs_beat_t;

  function automatic int unsigned VALID_BIT(input int unsigned w);
    return w - 1;
  endfunction

  // Keeps only the w-1 payload bits of a port1 vector of width w.
  function automatic logic [HS_MAX_W-2:0] payload_mask(input int unsigned w);
    return {(HS_MAX_W - 1){1'b1}} >> (HS_MAX_W - w);
  endfunction

  function automatic hs_beat_t unpack_port1(input logic [HS_MAX_W-1:0] p, input int unsigned w);
    hs_beat_t b;
    b.valid   = p[HS_IDX_W'(VALID_BIT(w))];
    b.payload = p[HS_MAX_W-2:0] & payload_mask(w);
    return b;
  endfunction

  function automatic logic [HS_MAX_W-1:0] pack_port1(input hs_beat_t b, input int unsigned w);
    logic [HS_MAX_W-1:0] p;
    p = {1'b0, b.payload & payload_mask(w)};
    p[HS_IDX_W'(VALID_BIT(w))] = b.valid;
    return p;
  endfunction

  function automatic logic [HS_MAX_W-1:0] pack_port2(input logic ready);
    logic [HS_MAX_W-1:0] p;
    p = '0;
    p[READY_BIT] = ready;
    return p;
  endfunction

  function automatic logic unpack_port2(input logic [HS_MAX_W-1:0] p);
    return p[READY_BIT];
  endfunction

endpackage

// File: rtl/handshake.sv
// Point-to-point handshake bundle: port1 carries valid/payload forward, port2 carries ready back.
interface handshake #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] port1;
  logic [WIDTH-1:0] port2;

  modport dir1 (output port1, input port2);
  modport dir2 (input port1, output port2);
endinterface

// File: rtl/hs_fifo_mem.sv
// DEPTH x (WIDTH-1) storage array: one synchronous write port, one asynchronous read port.
module hs_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-2:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-2:0] o_rdata
);

  logic [WIDTH-2:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/handshake_fifo.sv
// First-word-fall-through elastic buffer between two handshake interfaces.
// Define HANDSHAKE_FIFO_STATS_EN to add push/pop counters and a peak-occupancy port.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  handshake.dir2        up,
  handshake.dir1        dn,
  output logic [CW-1:0] level,
  output logic          full,
  output logic          empty
`ifdef HANDSHAKE_FIFO_STATS_EN
  ,
  output logic [31:0]   push_cnt,
  output logic [31:0]   pop_cnt,
  output logic [CW-1:0] peak
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_level, w_level_n;
  logic             r_ready;
  logic             w_push, w_pop, w_dn_valid, w_dn_ready;
  logic [WIDTH-2:0] w_rdata;
  hs_beat_t         w_up_beat, w_dn_beat;

  assign w_up_beat  = unpack_port1(HS_MAX_W'(up.port1), WIDTH);
  assign w_dn_ready = unpack_port2(HS_MAX_W'(dn.port2));

  assign w_dn_valid = (r_level != '0);
  assign w_push     = w_up_beat.valid & r_ready;
  assign w_pop      = w_dn_valid & w_dn_ready;
  assign w_level_n  = r_level + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
    end else begin
      // Explicit wrap so non-power-of-2 depths work.
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_level <= w_level_n;
      r_ready <= (w_level_n < CW'(DEPTH));
    end
  end

  hs_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_up_beat.payload[WIDTH-2:0]),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Payload is forced to zero whenever nothing is offered downstream.
  always_comb begin
    w_dn_beat       = '0;
    w_dn_beat.valid = w_dn_valid;
    if (w_dn_valid) begin
      w_dn_beat.payload = (HS_MAX_W - 1)'(w_rdata);
    end
  end

  assign dn.port1 = WIDTH'(pack_port1(w_dn_beat, WIDTH));
  assign up.port2 = WIDTH'(pack_port2(r_ready));

  assign level = r_level;
  assign full  = (r_level == CW'(DEPTH));
  assign empty = (r_level == '0);

`ifdef HANDSHAKE_FIFO_STATS_EN
  logic [31:0]   r_push_cnt, r_pop_cnt;
  logic [CW-1:0] r_peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
      r_peak     <= '0;
    end else begin
      if (w_push) r_push_cnt <= r_push_cnt + 32'd1;
      if (w_pop)  r_pop_cnt  <= r_pop_cnt + 32'd1;
      if (w_level_n > r_peak) r_peak <= w_level_n;
    end
  end

  assign push_cnt = r_push_cnt;
  assign pop_cnt  = r_pop_cnt;
  assign peak     = r_peak;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_level == CW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(w_pop && !w_push && (r_level == '0)));
  a_payload_in_range: assert property (@(posedge clk) disable iff (rst)
    ((w_up_beat.payload >> (WIDTH - 1)) == '0));

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: a DEPTH=4/WIDTH=32 instance and a DEPTH=3/WIDTH=8 instance.
module tb_handshake_fifo;

  localparam int unsigned W4 = 32, D4 = 4, CW4 = 3;
  localparam int unsigned W3 = 8,  D3 = 3, CW3 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst3;
  handshake #(.WIDTH(W4)) up4 ();
  handshake #(.WIDTH(W4)) dn4 ();
  handshake #(.WIDTH(W3)) up3 ();
  handshake #(.WIDTH(W3)) dn3 ();

  logic [CW4-1:0] level4;
  logic           full4, empty4;
  logic [CW3-1:0] level3;
  logic           full3, empty3;
`ifdef HANDSHAKE_FIFO_STATS_EN
  logic [31:0]    push_cnt4, pop_cnt4, push_cnt3, pop_cnt3;
  logic [CW4-1:0] peak4;
  logic [CW3-1:0] peak3;
`endif

  handshake_fifo #(.WIDTH(W4), .DEPTH(D4)) u_dut4 (
    .clk(clk), .rst(rst4), .up(up4), .dn(dn4),
    .level(level4), .full(full4), .empty(empty4)
`ifdef HANDSHAKE_FIFO_STATS_EN
    , .push_cnt(push_cnt4), .pop_cnt(pop_cnt4), .peak(peak4)
`endif
  );

  handshake_fifo #(.WIDTH(W3), .DEPTH(D3)) u_dut3 (
    .clk(clk), .rst(rst3), .up(up3), .dn(dn3),
    .level(level3), .full(full3), .empty(empty3)
`ifdef HANDSHAKE_FIFO_STATS_EN
    , .push_cnt(push_cnt3), .pop_cnt(pop_cnt3), .peak(peak3)
`endif
  );

  logic          up4_ready, dn4_valid, up3_ready, dn3_valid;
  logic [W4-2:0] dn4_data;
  logic [W3-2:0] dn3_data;
  assign up4_ready = up4.port2[0];
  assign dn4_valid = dn4.port1[W4-1];
  assign dn4_data  = dn4.port1[W4-2:0];
  assign up3_ready = up3.port2[0];
  assign dn3_valid = dn3.port1[W3-1];
  assign dn3_data  = dn3.port1[W3-2:0];

  int n_cmp = 0;
  int n_err = 0;

  task automatic drive4(input logic v, input logic [W4-2:0] p, input logic r);
    up4.port1 = {v, p};
    dn4.port2 = {{(W4 - 1){1'b0}}, r};
  endtask

  task automatic drive3(input logic v, input logic [W3-2:0] p, input logic r);
    up3.port1 = {v, p};
    dn3.port2 = {{(W3 - 1){1'b0}}, r};
  endtask

  task automatic test_reset();
    rst4 = 1'b1;
    drive4(1'b1, 31'h2A, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({up4_ready, dn4_valid, empty4, full4, level4, dn4_data} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 31'd0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b emp=%b full=%b lvl=%0d data=%h want 0 0 1 0 0 0",
               up4_ready, dn4_valid, empty4, full4, level4, dn4_data);
    end
`ifdef HANDSHAKE_FIFO_STATS_EN
    n_cmp++;
    if ({push_cnt4, pop_cnt4, peak4} !== {32'd0, 32'd0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_stats: got push=%0d pop=%0d peak=%0d want 0 0 0",
               push_cnt4, pop_cnt4, peak4);
    end
`endif
    rst4 = 1'b0;
    drive4(1'b0, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({up4_ready, level4, dn4_valid} !== {1'b1, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b lvl=%0d vld=%b want 1 0 0",
               up4_ready, level4, dn4_valid);
    end
  endtask

  task automatic test_fill();
    for (int p = 1; p <= 4; p++) begin
      drive4(1'b1, 31'(p), 1'b0);
      @(posedge clk);
      #1;
    end
    drive4(1'b1, 31'd5, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({up4_ready, full4, level4, dn4_valid, dn4_data} !==
        {1'b0, 1'b1, 3'd4, 1'b1, 31'd1}) begin
      n_err++;
      $display("FAIL fill_full: got rdy=%b full=%b lvl=%0d vld=%b data=%h want 0 1 4 1 1",
               up4_ready, full4, level4, dn4_valid, dn4_data);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp++;
    if ({up4_ready, level4, dn4_data} !== {1'b0, 3'd4, 31'd1}) begin
      n_err++;
      $display("FAIL fill_hold: got rdy=%b lvl=%0d data=%h want 0 4 1",
               up4_ready, level4, dn4_data);
    end
`ifdef HANDSHAKE_FIFO_STATS_EN
    n_cmp++;
    if ({push_cnt4, pop_cnt4, peak4} !== {32'd4, 32'd0, 3'd4}) begin
      n_err++;
      $display("FAIL fill_stats: got push=%0d pop=%0d peak=%0d want 4 0 4",
               push_cnt4, pop_cnt4, peak4);
    end
`endif
  endtask

  task automatic test_drain();
    logic xfer;
    drive4(1'b1, 31'd5, 1'b1);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({dn4_valid, dn4_data} !== {1'b1, 31'(i + 1)}) begin
        n_err++;
        $display("FAIL drain_word%0d: got vld=%b data=%h want 1 %h",
                 i, dn4_valid, dn4_data, i + 1);
      end
      xfer = up4_ready;
      @(posedge clk);
      #1;
      if (xfer) drive4(1'b0, '0, 1'b1);
      @(negedge clk);
    end
    n_cmp++;
    if ({empty4, dn4_valid, level4, dn4_data} !== {1'b1, 1'b0, 3'd0, 31'd0}) begin
      n_err++;
      $display("FAIL drain_empty: got emp=%b vld=%b lvl=%0d data=%h want 1 0 0 0",
               empty4, dn4_valid, level4, dn4_data);
    end
  endtask

  task automatic test_stream();
    logic [W4-2:0] base;
    base = 31'h100;
    drive4(1'b1, base, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 99) drive4(1'b0, '0, 1'b1);
      else         drive4(1'b1, base + 31'(i + 1), 1'b1);
      @(negedge clk);
      n_cmp++;
      if ({dn4_valid, dn4_data, level4, up4_ready} !== {1'b1, base + 31'(i), 3'd1, 1'b1}) begin
        n_err++;
        $display("FAIL stream_word%0d: got vld=%b data=%h lvl=%0d rdy=%b want 1 %h 1 1",
                 i, dn4_valid, dn4_data, level4, up4_ready, base + 31'(i));
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({empty4, dn4_valid} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL stream_end: got emp=%b vld=%b want 1 0", empty4, dn4_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive4(1'b1, 31'h77, 1'b0);
    @(posedge clk);
    #1;
    drive4(1'b1, 31'h78, 1'b0);
    @(posedge clk);
    #1;
    drive4(1'b1, 31'h79, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({level4, dn4_data} !== {3'd2, 31'h77}) begin
      n_err++;
      $display("FAIL midrst_pre: got lvl=%0d data=%h want 2 77", level4, dn4_data);
    end
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    drive4(1'b0, '0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({level4, dn4_valid, dn4_data, empty4, up4_ready} !== {3'd0, 1'b0, 31'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_post: got lvl=%0d vld=%b data=%h emp=%b rdy=%b want 0 0 0 1 0",
               level4, dn4_valid, dn4_data, empty4, up4_ready);
    end
`ifdef HANDSHAKE_FIFO_STATS_EN
    n_cmp++;
    if ({push_cnt4, pop_cnt4, peak4} !== {32'd0, 32'd0, 3'd0}) begin
      n_err++;
      $display("FAIL midrst_stats: got push=%0d pop=%0d peak=%0d want 0 0 0",
               push_cnt4, pop_cnt4, peak4);
    end
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({level4, dn4_valid, up4_ready} !== {3'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_nothing_out: got lvl=%0d vld=%b rdy=%b want 0 0 1",
               level4, dn4_valid, up4_ready);
    end
  endtask

  task automatic test_wrap();
    logic [W3-2:0] q[$];
    logic [W3-2:0] next_val, cur_pay, exp_data;
    logic          cur_v, cur_r, exp_ready, m_push, m_pop;
    next_val  = 7'd1;
    cur_v     = 1'b0;
    cur_r     = 1'b0;
    cur_pay   = '0;
    rst3      = 1'b0;
    drive3(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    exp_ready = 1'b1;
    // 10 random rounds of 4 cycles, then forced drain.
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      exp_data = (q.size() != 0) ? q[0] : '0;
      n_cmp++;
      if ({dn3_valid, up3_ready, level3, dn3_data} !==
          {q.size() != 0, exp_ready, CW3'(q.size()), exp_data}) begin
        n_err++;
        $display("FAIL wrap_cycle%0d: got vld=%b rdy=%b lvl=%0d data=%h want %b %b %0d %h",
                 i, dn3_valid, up3_ready, level3, dn3_data,
                 q.size() != 0, exp_ready, q.size(), exp_data);
      end
      m_pop  = (q.size() != 0) && cur_r;
      m_push = cur_v && exp_ready;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(cur_pay);
      exp_ready = (q.size() < D3);
      @(posedge clk);
      #1;
      if (!cur_v || m_push) begin
        cur_v = (i < 40) && ($urandom_range(0, 3) != 0);
        if (cur_v) begin
          cur_pay  = next_val;
          next_val = next_val + 7'd1;
        end
      end
      cur_r = (i >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      drive3(cur_v, cur_v ? cur_pay : '0, cur_r);
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    drive4(1'b0, '0, 1'b0);
    drive3(1'b0, '0, 1'b0);
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
